// File: rtl/fp_alu_byte_sequencer.sv
// fp_alu_byte_sequencer: byte-serial command loader and result streamer for a 32-bit FP ALU.
// Optional FP_SEQ_STATUS_BYTE_EN appends a fifth status byte (zero/inf/NaN/reserved-opcode flags).
module fp_alu_byte_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  in_data_i,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic        alu_op_o,
  input  logic [31:0] alu_out_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [7:0]  out_data_o,
  output logic        busy_o
);
  localparam logic [1:0] LOAD = 2'd0, SETTLE = 2'd1, SEND = 2'd2;
  localparam int WW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WW-1:0] WLAST = WW'(SETTLE_CYCLES - 1);
`ifdef FP_SEQ_STATUS_BYTE_EN
  localparam logic [3:0] SLAST = 4'd4;
`else
  localparam logic [3:0] SLAST = 4'd3;
`endif
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [3:0][7:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic op_q, op_d;
  logic [1:0] lane;
  logic [7:0] res_byte;
  // Operand bytes arrive MSB first, so byte k of a word lands in lane (-k mod 4)
  assign lane = 2'd0 - cnt_q[1:0];
  assign res_byte = res_q[2'd3 - cnt_q[1:0]];
  assign in_ready_o = state_q == LOAD;
  assign out_valid_o = state_q == SEND;
  assign busy_o = state_q != LOAD;
  assign alu_a_o = a_q;
  assign alu_b_o = b_q;
  assign alu_op_o = op_q;
`ifdef FP_SEQ_STATUS_BYTE_EN
  logic rsv_q;
  logic [7:0] e;
  logic [22:0] f;
  logic [7:0] status;
  assign e = {res_q[3][6:0], res_q[2][7]};
  assign f = {res_q[2][6:0], res_q[1], res_q[0]};
  assign status = {4'd0, rsv_q, &e && |f, &e && ~|f, ~|e && ~|f};
  assign out_data_o = state_q != SEND ? 8'd0 : cnt_q == 4'd4 ? status : res_byte;
  // Remember whether the opcode byte of the current frame had reserved bits set
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) rsv_q <= 1'b0;
    else if (in_ready_o && in_valid_i && cnt_q == 4'd0) rsv_q <= |in_data_i[7:1];
`else
  assign out_data_o = state_q == SEND ? res_byte : 8'd0;
`endif
  // Next-state: load frame bytes, count settle cycles, step through result bytes
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wait_d = wait_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    res_d = res_q;
    case (state_q)
      LOAD: if (in_valid_i) begin
        if (cnt_q == 4'd0) op_d = in_data_i[0];
        else if (cnt_q <= 4'd4) a_d[lane] = in_data_i;
        else b_d[lane] = in_data_i;
        cnt_d = cnt_q == 4'd8 ? 4'd0 : cnt_q + 4'd1;
        if (cnt_q == 4'd8) begin
          state_d = SETTLE;
          wait_d = '0;
        end
      end
      SETTLE: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WLAST) begin
          res_d = alu_out_i;
          state_d = SEND;
          wait_d = '0;
        end
      end
      SEND: if (out_ready_i) begin
        cnt_d = cnt_q == SLAST ? 4'd0 : cnt_q + 4'd1;
        if (cnt_q == SLAST) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end
  // State registers; reset drops any partially loaded or partially sent frame
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= LOAD;
      cnt_q <= 4'd0;
      wait_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= 1'b0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wait_q <= wait_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      res_q <= res_d;
    end
endmodule
